screen_mem_arbiter: RTL

Shares the single-port 8K×16 Hack screen RAM between three clients:
- the VGA scanout reader, which has highest priority and a fixed read latency;
- the Hack CPU memory-mapped screen port, which uses a req/ack handshake;
- a built-in background clear engine, which has lowest priority.

The block sits between the CPU bus decoder, the VGA timing generator and the screen RAM. It guarantees the VGA reader is never stalled.

---
 rtl/screen_mem_arbiter_pkg.sv | 22 ++
 rtl/screen_mem_arbiter_if.sv | 52 +++++
 rtl/screen_mem_arbiter_clear.sv | 37 +++
 rtl/screen_mem_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/screen_mem_arbiter_pkg.sv
// Shared types and defaults for the Hack screen RAM arbiter: grant encoding,
// CPU handshake FSM states and the default geometry of the screen memory.
package screen_arb_pkg;

    localparam int              AW_DEF      = 13;
    localparam int              DW_DEF      = 16;
    localparam logic [DW_DEF-1:0] CLR_VAL_DEF = 16'h0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        ACK     = 2'd2
    } cpu_state_t;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_VGA  = 2'd1,
        G_CPU  = 2'd2,
        G_CLR  = 2'd3
    } grant_t;

endpackage

// File: rtl/screen_mem_arbiter_if.sv
// Bus bundle between the arbiter, its clients (VGA, CPU, clear control) and
// the single-port screen RAM. The slave view is the arbiter itself.
interface screen_mem_arbiter_if
    import screen_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();

    logic          i_vga_req;
    logic [AW-1:0] i_vga_addr;
    logic [DW-1:0] o_vga_data;
    logic          o_vga_valid;

    logic          i_cpu_req;
    logic          i_cpu_we;
    logic [AW-1:0] i_cpu_addr;
    logic [DW-1:0] i_cpu_wdata;
    logic          o_cpu_ack;
    logic [DW-1:0] o_cpu_rdata;

    logic          i_clr_start;
    logic          o_clr_busy;

    logic [AW-1:0] o_ram_addr;
    logic          o_ram_we;
    logic [DW-1:0] o_ram_wdata;
    logic [DW-1:0] i_ram_rdata;

    modport slave (
        input  i_vga_req, i_vga_addr,
        output o_vga_data, o_vga_valid,
        input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
        output o_cpu_ack, o_cpu_rdata,
        input  i_clr_start,
        output o_clr_busy,
        output o_ram_addr, o_ram_we, o_ram_wdata,
        input  i_ram_rdata
    );

    modport master (
        output i_vga_req, i_vga_addr,
        input  o_vga_data, o_vga_valid,
        output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
        input  o_cpu_ack, o_cpu_rdata,
        output i_clr_start,
        input  o_clr_busy,
        input  o_ram_addr, o_ram_we, o_ram_wdata,
        output i_ram_rdata
    );

endinterface

// File: rtl/screen_mem_arbiter_clear.sv
// Background full-screen clear engine: walks every word address once per
// start pulse, advancing only on cycles the arbiter hands it the RAM.
module screen_clear #(
    parameter int AW = 13
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_grant,
    output logic [AW-1:0] o_addr,
    output logic          o_busy
);

    logic [AW-1:0] cnt;
    logic          busy;

    // A start pulse always wins, including over the final write of a pass,
    // so a restart never lets busy drop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (i_start) begin
            cnt  <= '0;
            busy <= 1'b1;
        end else if (i_grant) begin
            cnt <= cnt + 1'b1;
            if (cnt == '1) begin
                busy <= 1'b0;
            end
        end
    end

    assign o_addr = cnt;
    assign o_busy = busy;

endmodule

// File: rtl/screen_mem_arbiter.sv
// Fixed-priority arbiter for the Hack screen RAM: VGA scanout (never stalled),
// CPU req/ack port, then the background clear engine.
module screen_mem_arbiter
    import screen_arb_pkg::*;
#(
    parameter int            AW      = AW_DEF,
    parameter int            DW      = DW_DEF,
    parameter logic [DW-1:0] CLR_VAL = CLR_VAL_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    screen_mem_arbiter_if.slave  bus
);

    grant_t        grant;
    cpu_state_t    state, state_nxt;
    logic          cpu_capture;
    logic          cpu_ack;

    logic [AW-1:0] clr_addr;
    logic          clr_busy;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;

    logic          vld_p0;
    logic          vld_p1;
    logic [DW-1:0] vga_data_p1;
    logic [DW-1:0] cpu_rdata;

    // The port is forced idle while reset is asserted so the RAM sees no
    // stray access during an asynchronous reset.
    always_comb begin
        grant = G_NONE;
        if (!i_rst_n) begin
            grant = G_NONE;
        end else if (bus.i_vga_req) begin
            grant = G_VGA;
        end else if (state == IDLE && bus.i_cpu_req) begin
            grant = G_CPU;
        end else if (clr_busy) begin
            grant = G_CLR;
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        unique case (grant)
            G_VGA: begin
                ram_addr = bus.i_vga_addr;
            end
            G_CPU: begin
                ram_addr  = bus.i_cpu_addr;
                ram_we    = bus.i_cpu_we;
                ram_wdata = bus.i_cpu_we ? bus.i_cpu_wdata : '0;
            end
            G_CLR: begin
                ram_addr  = clr_addr;
                ram_we    = 1'b1;
                ram_wdata = CLR_VAL;
            end
            default: begin
            end
        endcase
    end

    screen_clear #(
        .AW (AW)
    ) u_clear (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (bus.i_clr_start),
        .i_grant (grant == G_CLR),
        .o_addr  (clr_addr),
        .o_busy  (clr_busy)
    );

    // p0: address presented to RAM; p1: RAM data captured into the output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            vga_data_p1 <= '0;
        end else begin
            vld_p0 <= (grant == G_VGA);
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                vga_data_p1 <= bus.i_ram_rdata;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            cpu_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (cpu_capture) begin
                cpu_rdata <= bus.i_ram_rdata;
            end
        end
    end

    // Request is only re-sampled from IDLE, so a client still holding req
    // during ACK does not start a second transaction.
    always_comb begin
        state_nxt   = state;
        cpu_capture = 1'b0;
        cpu_ack     = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant == G_CPU) begin
                    state_nxt = bus.i_cpu_we ? ACK : RD_WAIT;
                end
            end
            RD_WAIT: begin
                cpu_capture = 1'b1;
                state_nxt   = ACK;
            end
            ACK: begin
                cpu_ack   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.o_vga_data  = vga_data_p1;
    assign bus.o_vga_valid = vld_p1;
    assign bus.o_cpu_ack   = cpu_ack;
    assign bus.o_cpu_rdata = cpu_rdata;
    assign bus.o_clr_busy  = clr_busy;
    assign bus.o_ram_addr  = ram_addr;
    assign bus.o_ram_we    = ram_we;
    assign bus.o_ram_wdata = ram_wdata;

endmodule
